router_rr_n: RTL and testbench

Parametrised N-port packet router with per-output round-robin arbitration, sitting between the serial ingress lanes driven by the bench driver and the egress lanes observed by the output monitor. Each input lane carries a framed packet whose leading bits give the destination port. The packet waits for a grant, then its payload is forwarded with one-cycle latency. This generation adds any port count, a configurable lane width, fair arbitration and dropping of out-of-range destinations.

---
 rtl/router_rr_n_if.sv | 22 ++
 rtl/router_rr_n.sv | 193 +++++++++++++++++++
 tb/tb_router_rr_n.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/router_rr_n_if.sv
// rtl/router_rr_n_if.sv - ingress/egress lane bundle between source driver and router_rr_n
interface router_rr_n_if #(
  parameter int NPORT  = 4,
  parameter int DATA_W = 1
);
  logic [NPORT-1:0]        i_frame;
  logic [NPORT-1:0]        i_valid;
  logic [NPORT*DATA_W-1:0] i_data;
  logic [NPORT-1:0]        o_grant;
  logic [NPORT-1:0]        o_valid;
  logic [NPORT*DATA_W-1:0] o_data;

  modport master (
    output i_frame, i_valid, i_data,
    input  o_grant, o_valid, o_data
  );

  modport slave (
    input  i_frame, i_valid, i_data,
    output o_grant, o_valid, o_data
  );
endinterface

// File: rtl/router_rr_n.sv
// rtl/router_rr_n.sv - N-port serial-address packet router with per-output round-robin arbitration
module router_rr_n #(
  parameter int NPORT  = 4,
  parameter int DATA_W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  router_rr_n_if.slave bus
);
  localparam int ADDR_W = $clog2(NPORT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_REQ,
    S_XFER,
    S_DROP
  } state_t;

  // per-input framing state
  state_t            state_q [NPORT];
  state_t            state_d [NPORT];
  logic [ADDR_W-1:0] addr_q  [NPORT];
  logic [ADDR_W-1:0] addr_d  [NPORT];
  logic [ADDR_W-1:0] cnt_q   [NPORT];
  logic [ADDR_W-1:0] cnt_d   [NPORT];

  // per-output ownership and round-robin pointer
  logic [NPORT-1:0]  owned_q, owned_d;
  logic [ADDR_W-1:0] owner_q [NPORT];
  logic [ADDR_W-1:0] owner_d [NPORT];
  logic [ADDR_W-1:0] ptr_q   [NPORT];
  logic [ADDR_W-1:0] ptr_d   [NPORT];

  // arbitration results
  logic [NPORT-1:0]  win_valid;
  logic [ADDR_W-1:0] win_idx [NPORT];
  logic [NPORT-1:0]  granted;

  // registered outputs
  logic [NPORT-1:0]        grant_q, grant_d;
  logic [NPORT-1:0]        valid_q, valid_d;
  logic [NPORT*DATA_W-1:0] data_q, data_d;

  assign bus.o_grant = grant_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;

  // round-robin search per unowned output, starting one past the last winner
  always_comb begin
    int c;
    c       = 0;
    granted = '0;
    for (int d = 0; d < NPORT; d++) begin
      win_valid[d] = 1'b0;
      win_idx[d]   = '0;
      for (int i = 1; i <= NPORT; i++) begin
        c = (int'(ptr_q[d]) + i) % NPORT;
        if (!win_valid[d] && !owned_q[d] && state_q[c] == S_REQ &&
            bus.i_frame[c] && addr_q[c] == ADDR_W'(d)) begin
          win_valid[d] = 1'b1;
          win_idx[d]   = ADDR_W'(c);
        end
      end
    end
    for (int p = 0; p < NPORT; p++) begin
      for (int d = 0; d < NPORT; d++) begin
        if (win_valid[d] && win_idx[d] == ADDR_W'(p)) begin
          granted[p] = 1'b1;
        end
      end
    end
  end

  // per-input next state: address shift-in, request, transfer/drop, abort
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      state_d[p] = state_q[p];
      addr_d[p]  = addr_q[p];
      cnt_d[p]   = cnt_q[p];
      case (state_q[p])
        S_IDLE: begin
          if (bus.i_frame[p]) begin
            addr_d[p]    = '0;
            addr_d[p][0] = bus.i_data[p*DATA_W];
            cnt_d[p]     = ADDR_W'(1);
            state_d[p]   = (ADDR_W > 1) ? S_ADDR : S_REQ;
          end
        end
        S_ADDR: begin
          if (!bus.i_frame[p]) begin
            state_d[p] = S_IDLE;
          end else begin
            addr_d[p][cnt_q[p]] = bus.i_data[p*DATA_W];
            cnt_d[p]            = cnt_q[p] + ADDR_W'(1);
            if (cnt_q[p] == ADDR_W'(ADDR_W - 1)) begin
              state_d[p] = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (!bus.i_frame[p]) begin
            state_d[p] = S_IDLE;
          end else if (int'(addr_q[p]) >= NPORT) begin
            state_d[p] = S_DROP;
          end else if (granted[p]) begin
            state_d[p] = S_XFER;
          end
        end
        S_XFER, S_DROP: begin
          if (!bus.i_frame[p]) begin
            state_d[p] = S_IDLE;
          end
        end
        default: state_d[p] = S_IDLE;
      endcase
    end
  end

  // output ownership: claimed on a grant, released when the owner's frame ends
  always_comb begin
    for (int d = 0; d < NPORT; d++) begin
      owned_d[d] = owned_q[d];
      owner_d[d] = owner_q[d];
      ptr_d[d]   = ptr_q[d];
      if (win_valid[d]) begin
        owned_d[d] = 1'b1;
        owner_d[d] = win_idx[d];
        ptr_d[d]   = win_idx[d];
      end else if (owned_q[d] && !bus.i_frame[owner_q[d]]) begin
        owned_d[d] = 1'b0;
      end
    end
  end

  // output decode: grant follows the next state, payload forwards from the owner
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      grant_d[p] = (state_d[p] == S_XFER) || (state_d[p] == S_DROP);
    end
    valid_d = '0;
    data_d  = '0;
    for (int d = 0; d < NPORT; d++) begin
      if (owned_q[d] && bus.i_valid[owner_q[d]]) begin
        valid_d[d]                   = 1'b1;
        data_d[d*DATA_W +: DATA_W]   = bus.i_data[int'(owner_q[d])*DATA_W +: DATA_W];
      end
    end
  end

  // per-input state register
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (!reset_n) begin
        state_q[p] <= S_IDLE;
        addr_q[p]  <= '0;
        cnt_q[p]   <= '0;
      end else begin
        state_q[p] <= state_d[p];
        addr_q[p]  <= addr_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
    end
  end

  // per-output ownership register; pointer reset gives input 0 first priority
  always_ff @(posedge clk) begin
    for (int d = 0; d < NPORT; d++) begin
      if (!reset_n) begin
        owned_q[d] <= 1'b0;
        owner_q[d] <= '0;
        ptr_q[d]   <= ADDR_W'(NPORT - 1);
      end else begin
        owned_q[d] <= owned_d[d];
        owner_q[d] <= owner_d[d];
        ptr_q[d]   <= ptr_d[d];
      end
    end
  end

  // output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_q <= '0;
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_router_rr_n.sv
// tb/tb_router_rr_n.sv - self-checking bench for router_rr_n
module tb_router_rr_n;
  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q [4][$];

  router_rr_n_if #(.NPORT(4), .DATA_W(1)) b4 ();
  router_rr_n_if #(.NPORT(3), .DATA_W(1)) b3 ();

  router_rr_n #(.NPORT(4), .DATA_W(1)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));
  router_rr_n #(.NPORT(3), .DATA_W(1)) u3 (.clk(clk), .reset_n(reset_n), .bus(b3));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lane(input int p, input logic f, input logic v, input logic d);
    b4.i_frame[p] = f;
    b4.i_valid[p] = v;
    b4.i_data[p]  = d;
  endtask

  // drive a beat on input p and record it for output dst when valid
  task automatic beat(input int p, input logic f, input logic v, input logic d, input int dst);
    lane(p, f, v, d);
    if (v) exp_q[dst].push_back(d);
  endtask

  // two LSB-first address cycles then the request edge for every input in mask
  task automatic addr2(input logic [3:0] mask, input logic [7:0] a);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 4; p++) if (mask[p]) lane(p, 1'b1, 1'b0, a[2*p+k]);
      tick();
    end
    chk("grant_early", 32'(b4.o_grant & mask), 32'd0);
    for (int p = 0; p < 4; p++) if (mask[p]) lane(p, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  // egress monitor: every valid beat must match the head of its output's queue
  always @(negedge clk) begin
    logic e;
    for (int d = 0; d < 4; d++) begin
      if (b4.o_valid[d]) begin
        if (exp_q[d].size() == 0) begin
          chk($sformatf("unexpected_valid%0d", d), 32'(b4.o_valid[d]), 32'd0);
        end else begin
          e = exp_q[d].pop_front();
          chk($sformatf("o_data%0d", d), 32'(b4.o_data[d]), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [7:0]  pat;
    logic [3:0]  gv;
    logic [3:0]  gd;
    logic [15:0] ppat;

    reset_n = 1'b0;
    b4.i_frame = '0; b4.i_valid = '0; b4.i_data = '0;
    b3.i_frame = '0; b3.i_valid = '0; b3.i_data = '0;
    tick();
    tick();
    chk("rst_grant", 32'(b4.o_grant), 32'd0);
    chk("rst_valid", 32'(b4.o_valid), 32'd0);
    chk("rst_data",  32'(b4.o_data),  32'd0);
    chk("rst3_grant", 32'(b3.o_grant), 32'd0);
    reset_n = 1'b1;

    // uncontended: input 0 -> output 2, 0xA5 bit-serial
    addr2(4'b0001, 8'h02);
    chk("unc_grant", 32'(b4.o_grant), 32'(4'b0001));
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      beat(0, i != 7, 1'b1, pat[i], 2);
      tick();
      chk("unc_valid", 32'(b4.o_valid), 32'(4'b0100));
      chk("unc_grant_hold", 32'(b4.o_grant[0]), 32'(i != 7));
    end
    lane(0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("unc_idle_valid", 32'(b4.o_valid), 32'd0);

    // contention round A: inputs 1 and 3 -> output 0 with ptr[0]=3
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    addr2(4'b1010, 8'h00);
    chk("contA_grant", 32'(b4.o_grant), 32'(4'b0010));
    beat(1, 1'b1, 1'b1, 1'b1, 0);
    lane(3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("contA_hold", 32'(b4.o_grant), 32'(4'b0010));
    beat(1, 1'b0, 1'b1, 1'b0, 0);
    tick();
    chk("contA_release", 32'(b4.o_grant), 32'd0);
    lane(1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("contA_second", 32'(b4.o_grant), 32'(4'b1000));
    beat(3, 1'b0, 1'b1, 1'b1, 0);
    tick();
    chk("contA_end", 32'(b4.o_grant), 32'd0);
    lane(3, 1'b0, 1'b0, 1'b0);
    tick();

    // round B: ptr[0]=3 so input 1 wins again; input 3 aborts from REQ
    addr2(4'b1010, 8'h00);
    chk("contB_grant", 32'(b4.o_grant), 32'(4'b0010));
    beat(1, 1'b0, 1'b1, 1'b1, 0);
    lane(3, 1'b0, 1'b0, 1'b0);
    tick();
    lane(1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("abort_req_grant", 32'(b4.o_grant), 32'd0);

    // round C: ptr[0]=1 so input 3 wins
    addr2(4'b1010, 8'h00);
    chk("contC_grant", 32'(b4.o_grant), 32'(4'b1000));
    beat(3, 1'b0, 1'b1, 1'b0, 0);
    lane(1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("contC_end", 32'(b4.o_grant), 32'd0);
    lane(3, 1'b0, 1'b0, 1'b0);
    tick();

    // gaps: input 2 -> output 1 with valid pattern 1,0,0,1
    addr2(4'b0100, 8'h10);
    chk("gap_grant", 32'(b4.o_grant), 32'(4'b0100));
    gv = 4'b1001;
    gd = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      beat(2, k != 3, gv[k], gd[k], 1);
      tick();
      chk("gap_valid", 32'(b4.o_valid), 32'({2'b00, gv[k], 1'b0}));
    end
    chk("gap_release", 32'(b4.o_grant), 32'd0);
    lane(2, 1'b0, 1'b0, 1'b0);
    tick();

    // abort during address phase: no grant, no output
    lane(0, 1'b1, 1'b0, 1'b1);
    tick();
    lane(0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("abort_addr_grant", 32'(b4.o_grant), 32'd0);
    chk("abort_addr_valid", 32'(b4.o_valid), 32'd0);

    // drop on the 3-port router: address 3 is out of range
    b3.i_frame[0] = 1'b1;
    b3.i_data[0]  = 1'b1;
    tick();
    tick();
    b3.i_data[0] = 1'b0;
    tick();
    chk("drop_grant", 32'(b3.o_grant), 32'(3'b001));
    for (int k = 0; k < 3; k++) begin
      b3.i_frame[0] = (k != 2);
      b3.i_valid[0] = 1'b1;
      b3.i_data[0]  = k[0];
      tick();
      chk("drop_valid", 32'(b3.o_valid), 32'd0);
      chk("drop_grant_hold", 32'(b3.o_grant), 32'(k != 2));
    end
    b3.i_frame = '0; b3.i_valid = '0; b3.i_data = '0;
    tick();

    // parallel: 0->3, 1->2, 2->1, 3->0
    addr2(4'b1111, 8'h1B);
    chk("par_grant", 32'(b4.o_grant), 32'(4'b1111));
    ppat = 16'h3C96;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) beat(p, k != 3, 1'b1, ppat[4*p+k], 3 - p);
      tick();
      chk("par_valid", 32'(b4.o_valid), 32'(4'b1111));
    end
    chk("par_release", 32'(b4.o_grant), 32'd0);
    b4.i_frame = '0; b4.i_valid = '0; b4.i_data = '0;
    tick();

    // reset mid-transfer: input 1 -> output 0, then reset with a beat on the lane
    addr2(4'b0010, 8'h00);
    chk("rstx_grant", 32'(b4.o_grant), 32'(4'b0010));
    beat(1, 1'b1, 1'b1, 1'b1, 0);
    tick();
    beat(1, 1'b1, 1'b1, 1'b0, 0);
    tick();
    lane(1, 1'b1, 1'b1, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("rstx_grant0", 32'(b4.o_grant), 32'd0);
    chk("rstx_valid0", 32'(b4.o_valid), 32'd0);
    chk("rstx_data0",  32'(b4.o_data),  32'd0);
    lane(1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();

    // ptr[0] back to NPORT-1: inputs 0 and 2 contend, input 0 must win
    addr2(4'b0101, 8'h00);
    chk("ptr_after_reset", 32'(b4.o_grant), 32'(4'b0001));
    beat(0, 1'b0, 1'b1, 1'b1, 0);
    lane(2, 1'b0, 1'b0, 1'b0);
    tick();
    chk("final_release", 32'(b4.o_grant), 32'd0);
    lane(0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    for (int d = 0; d < 4; d++) begin
      chk($sformatf("sb_empty%0d", d), 32'(exp_q[d].size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
